ssp_fifo_ctrl: RTL and testbench
================================

Name: ssp_fifo_ctrl

Overview:
- Transmit and receive FIFO pair for the PL022-style SSP.
- Sits between the APB register block and the serial shift engine.
- Buffers SSPDR writes toward the shifter and received frames toward the APB side.
- Generates the status vector {BSY,RFF,RNE,TNF,TFE} and raw interrupt requests {RT,RX,TX,OVR} that the register block consumes.

Parameters:
DW, 16, data width of each FIFO entry
DEPTH, 8, entries per FIFO (power of two)
AW, 3, log2(DEPTH)
RT_TIMEOUT, 64, PCLK cycles of RX inactivity before the receive-timeout request

Ports:
PCLK  in  1  system clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
sse  in  1  port enable (SSPCR1[1]); used only for BSY
tx_wr  in  1  APB write strobe to SSPDR (one cycle per write)
tx_wdata  in  DW  data for tx_wr
rx_rd  in  1  APB read strobe of SSPDR (one cycle per read)
rx_rdata  out  DW  RX FIFO head (show-ahead); 0 when empty
tx_pop  in  1  shifter consumes TX head
tx_rdata  out  DW  TX FIFO head (show-ahead); 0 when empty
tx_empty  out  1  TX FIFO empty (to shifter)
rx_push  in  1  shifter delivers a received frame
rx_wdata  in  DW  data for rx_push
core_busy  in  1  shifter is mid-frame
ovr_clr  in  1  SSPICR bit0 write pulse, clears OVR
rt_clr  in  1  SSPICR bit1 write pulse, clears RT
tx_level  out  AW+1  TX occupancy 0..DEPTH
rx_level  out  AW+1  RX occupancy 0..DEPTH
ssp_status  out  5  {BSY,RFF,RNE,TNF,TFE}
intr_raw  out  4  {RT,RX,TX,OVR}

Behaviour:
- Clock and reset: one clock, PCLK. Reset is asynchronous and active-low, PRESETn.
- Reset state:
  - All pointers and levels = 0; rx_rdata and tx_rdata = 0.
  - ssp_status = 5'b00011 (TNF=1, TFE=1).
  - OVR, RT and the timeout counter = 0; intr_raw = 4'b0010 (TX request active since TX is empty).
  - Storage contents are don't-care.
- Reset mid-operation: everything returns to the reset state immediately; entries in flight are lost.
- Each FIFO: circular buffer with AW-bit read/write pointers that wrap DEPTH-1 -> 0, plus an AW+1-bit level counter.
- Write and pop take effect at the clock edge. Head outputs update the cycle after the edge (registered pointer, combinational head mux).
- TX FIFO:
  - tx_wr when tx_level==DEPTH: data dropped, no flag.
  - tx_pop when empty: ignored.
  - tx_wr and tx_pop in the same cycle with 0<level<DEPTH: level unchanged, both pointers advance.
  - Simultaneous tx_wr and tx_pop at full: pop proceeds, write accepted, level stays DEPTH.
  - Simultaneous tx_wr and tx_pop at empty: write accepted, pop ignored, level becomes 1.
- RX FIFO:
  - rx_rd when empty: ignored, rx_rdata stays 0.
  - rx_push when full: data dropped and OVR set (sticky).
  - Simultaneous rx_push and rx_rd at full: read proceeds, push accepted, OVR not set.
  - Simultaneous rx_push and rx_rd at empty: push accepted, read ignored.
- Status, combinational from registered state:
  - TFE = (tx_level==0)
  - TNF = (tx_level!=DEPTH)
  - RNE = (rx_level!=0)
  - RFF = (rx_level==DEPTH)
  - BSY = core_busy | (sse & ~TFE)
- Raw interrupts:
  - TX = (tx_level <= DEPTH/2).
  - RX = (rx_level >= DEPTH/2).
  - OVR is set by an overflowing push and cleared by ovr_clr. If set and clear coincide, set wins.
  - RT counter:
    - Resets to 0 on any rx_push, on any rx_rd, or while the RX FIFO is empty.
    - Otherwise increments, saturating at RT_TIMEOUT.
    - RT sets when the counter reaches RT_TIMEOUT-1 and increments.
    - RT clears on rt_clr, on rx_rd, or when the RX FIFO becomes empty.
    - If a set and rt_clr coincide, clear wins.
    - After rt_clr, RT re-fires only after a fresh RT_TIMEOUT inactivity window.
- Latency: status and intr_raw reflect a push/pop/write/read in the cycle after its edge.

Test Plan:
1. Reset, then write 8 frames 0x1111..0x8888 via tx_wr -> TFE 1->0 after first edge, TNF=0 after 8th; 9th write dropped, tx_level=8; 8 tx_pops return 0x1111..0x8888 in order, then TFE=1.
2. Wrap-around: 5 writes, 5 pops, 8 writes, 8 pops -> all data in order, pointers wrap, no loss.
3. RX overflow: 8 rx_push -> RFF=1, RX=1; 9th push with 0xDEAD -> OVR=1, rx_level=8, 0xDEAD never read; ovr_clr pulse -> OVR=0 next cycle.
4. Receive timeout: one rx_push of 0x00A5, then 64 idle cycles -> RT=1 exactly once at cycle 64; rx_rd returns 0x00A5, RT=0, RNE=0.
5. Simultaneous events: rx_push+rx_rd at full -> level stays 8, OVR=0; tx_wr+tx_pop at empty -> tx_level=1, tx_rdata = written value.
6. BSY: sse=0 with TX non-empty and core_busy=0 -> BSY=0; sse=1 -> BSY=1; TX empty and core_busy=1 -> BSY=1.

Source files
------------

// File: rtl/ssp_fifo_ctrl.sv
// Transmit/receive FIFO pair for a PL022-style SSP: buffers SSPDR traffic between
// the APB register block and the shift engine and derives status and raw interrupts.
module ssp_fifo_ctrl #(
    parameter int DW         = 16,
    parameter int DEPTH      = 8,
    parameter int AW         = 3,
    parameter int RT_TIMEOUT = 64
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          sse,
    input  logic          tx_wr,
    input  logic [DW-1:0] tx_wdata,
    input  logic          rx_rd,
    output logic [DW-1:0] rx_rdata,
    input  logic          tx_pop,
    output logic [DW-1:0] tx_rdata,
    output logic          tx_empty,
    input  logic          rx_push,
    input  logic [DW-1:0] rx_wdata,
    input  logic          core_busy,
    input  logic          ovr_clr,
    input  logic          rt_clr,
    output logic [AW:0]   tx_level,
    output logic [AW:0]   rx_level,
    output logic [4:0]    ssp_status,
    output logic [3:0]    intr_raw
);

    localparam int CW = $clog2(RT_TIMEOUT + 1);
    localparam logic [AW:0]   LVL_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_HALF = (AW+1)'(DEPTH / 2);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(RT_TIMEOUT);
    localparam logic [CW-1:0] CNT_ARM  = CW'(RT_TIMEOUT - 1);

    logic [DW-1:0] tx_mem_r [DEPTH];
    logic [DW-1:0] rx_mem_r [DEPTH];
    logic [AW-1:0] tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
    logic [AW:0]   tx_level_r, rx_level_r, tx_level_nx_s, rx_level_nx_s;
    logic [CW-1:0] rt_cnt_r;
    logic          ovr_r, rt_r;
    logic          tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
    logic          tx_wr_ok_s, tx_pop_ok_s, rx_push_ok_s, rx_rd_ok_s;
    logic          ovr_set_s, rt_hold_s, rt_set_s, rt_clear_s, bsy_s;

    assign tx_empty_s   = (tx_level_r == LVL_ZERO);
    assign tx_full_s    = (tx_level_r == LVL_FULL);
    assign rx_empty_s   = (rx_level_r == LVL_ZERO);
    assign rx_full_s    = (rx_level_r == LVL_FULL);
    // A write into a full FIFO is only accepted when the head leaves in the same edge.
    assign tx_pop_ok_s  = tx_pop & ~tx_empty_s;
    assign tx_wr_ok_s   = tx_wr & (~tx_full_s | tx_pop_ok_s);
    assign rx_rd_ok_s   = rx_rd & ~rx_empty_s;
    assign rx_push_ok_s = rx_push & (~rx_full_s | rx_rd_ok_s);
    assign ovr_set_s    = rx_push & rx_full_s & ~rx_rd_ok_s;

    // Next TX occupancy from accepted write/pop.
    always_comb begin
        tx_level_nx_s = tx_level_r;
        case ({tx_wr_ok_s, tx_pop_ok_s})
            2'b10:   tx_level_nx_s = tx_level_r + LVL_ONE;
            2'b01:   tx_level_nx_s = tx_level_r - LVL_ONE;
            default: tx_level_nx_s = tx_level_r;
        endcase
    end

    // Next RX occupancy from accepted push/read.
    always_comb begin
        rx_level_nx_s = rx_level_r;
        case ({rx_push_ok_s, rx_rd_ok_s})
            2'b10:   rx_level_nx_s = rx_level_r + LVL_ONE;
            2'b01:   rx_level_nx_s = rx_level_r - LVL_ONE;
            default: rx_level_nx_s = rx_level_r;
        endcase
    end

    // FIFO storage; contents are not reset.
    always_ff @(posedge PCLK) begin
        if (tx_wr_ok_s) tx_mem_r[tx_wptr_r] <= tx_wdata;
        if (rx_push_ok_s) rx_mem_r[rx_wptr_r] <= rx_wdata;
    end

    // Pointers and levels for both FIFOs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_wptr_r  <= PTR_ZERO;
            tx_rptr_r  <= PTR_ZERO;
            rx_wptr_r  <= PTR_ZERO;
            rx_rptr_r  <= PTR_ZERO;
            tx_level_r <= LVL_ZERO;
            rx_level_r <= LVL_ZERO;
        end else begin
            if (tx_wr_ok_s)   tx_wptr_r <= tx_wptr_r + PTR_ONE;
            if (tx_pop_ok_s)  tx_rptr_r <= tx_rptr_r + PTR_ONE;
            if (rx_push_ok_s) rx_wptr_r <= rx_wptr_r + PTR_ONE;
            if (rx_rd_ok_s)   rx_rptr_r <= rx_rptr_r + PTR_ONE;
            tx_level_r <= tx_level_nx_s;
            rx_level_r <= rx_level_nx_s;
        end
    end

    // The timeout window restarts on any RX activity and cannot re-arm while saturated.
    assign rt_hold_s  = rx_push | rx_rd | rx_empty_s;
    assign rt_set_s   = ~rt_hold_s & (rt_cnt_r == CNT_ARM);
    assign rt_clear_s = rt_clr | rx_rd | rx_empty_s;

    // Sticky overrun, receive-timeout flag and inactivity counter.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ovr_r    <= 1'b0;
            rt_r     <= 1'b0;
            rt_cnt_r <= CNT_ZERO;
        end else begin
            ovr_r <= ovr_set_s | (ovr_r & ~ovr_clr);
            if (rt_clear_s)    rt_r <= 1'b0;
            else if (rt_set_s) rt_r <= 1'b1;
            if (rt_hold_s)                rt_cnt_r <= CNT_ZERO;
            else if (rt_cnt_r != CNT_MAX) rt_cnt_r <= rt_cnt_r + CNT_ONE;
        end
    end

    assign bsy_s      = core_busy | (sse & ~tx_empty_s);
    assign tx_rdata   = tx_empty_s ? {DW{1'b0}} : tx_mem_r[tx_rptr_r];
    assign rx_rdata   = rx_empty_s ? {DW{1'b0}} : rx_mem_r[rx_rptr_r];
    assign tx_empty   = tx_empty_s;
    assign tx_level   = tx_level_r;
    assign rx_level   = rx_level_r;
    assign ssp_status = {bsy_s, rx_full_s, ~rx_empty_s, ~tx_full_s, tx_empty_s};
    assign intr_raw   = {rt_r, (rx_level_r >= LVL_HALF), (tx_level_r <= LVL_HALF), ovr_r};

endmodule

// File: tb/tb_ssp_fifo_ctrl.sv
// Directed bench for ssp_fifo_ctrl: a vector table for FIFO/status behaviour plus
// hand-written sequences for the receive timeout and asynchronous reset.
module tb_ssp_fifo_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        sse, tx_wr, rx_rd, tx_pop, rx_push, core_busy, ovr_clr, rt_clr;
    logic [15:0] tx_wdata, rx_wdata, rx_rdata, tx_rdata;
    logic        tx_empty;
    logic [3:0]  tx_level, rx_level;
    logic [4:0]  ssp_status;
    logic [3:0]  intr_raw;

    int n_vec  = 0;
    int n_fail = 0;
    int n_cmp  = 0;

    ssp_fifo_ctrl #(.DW(16), .DEPTH(8), .AW(3), .RT_TIMEOUT(64)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .sse(sse), .tx_wr(tx_wr), .tx_wdata(tx_wdata),
        .rx_rd(rx_rd), .rx_rdata(rx_rdata), .tx_pop(tx_pop), .tx_rdata(tx_rdata),
        .tx_empty(tx_empty), .rx_push(rx_push), .rx_wdata(rx_wdata), .core_busy(core_busy),
        .ovr_clr(ovr_clr), .rt_clr(rt_clr), .tx_level(tx_level), .rx_level(rx_level),
        .ssp_status(ssp_status), .intr_raw(intr_raw)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        tx_wr;
        logic [15:0] tx_wdata;
        logic        tx_pop;
        logic        rx_push;
        logic [15:0] rx_wdata;
        logic        rx_rd;
        logic        sse;
        logic        core_busy;
        logic        ovr_clr;
        logic [3:0]  e_txl;
        logic [3:0]  e_rxl;
        logic [4:0]  e_st;
        logic [3:0]  e_ir;
        logic [15:0] e_txd;
        logic [15:0] e_rxd;
        string       name;
    } vec_t;

    vec_t vq[$];
    vec_t v;

    function automatic vec_t idle_v(input string nm);
        vec_t r;
        r.tx_wr = 1'b0; r.tx_wdata = 16'h0000; r.tx_pop = 1'b0;
        r.rx_push = 1'b0; r.rx_wdata = 16'h0000; r.rx_rd = 1'b0;
        r.sse = 1'b0; r.core_busy = 1'b0; r.ovr_clr = 1'b0;
        r.e_txl = 4'd0; r.e_rxl = 4'd0; r.e_st = 5'b00011; r.e_ir = 4'b0010;
        r.e_txd = 16'h0000; r.e_rxd = 16'h0000; r.name = nm;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        @(negedge PCLK);
        tx_wr = x.tx_wr; tx_wdata = x.tx_wdata; tx_pop = x.tx_pop;
        rx_push = x.rx_push; rx_wdata = x.rx_wdata; rx_rd = x.rx_rd;
        sse = x.sse; core_busy = x.core_busy; ovr_clr = x.ovr_clr; rt_clr = 1'b0;
        @(posedge PCLK);
        #1;
        n_vec++;
        chk({x.name, " tx_level"}, 16'(tx_level), 16'(x.e_txl));
        chk({x.name, " rx_level"}, 16'(rx_level), 16'(x.e_rxl));
        chk({x.name, " status"}, 16'(ssp_status), 16'(x.e_st));
        chk({x.name, " intr"}, 16'(intr_raw), 16'(x.e_ir));
        chk({x.name, " tx_rdata"}, tx_rdata, x.e_txd);
        chk({x.name, " rx_rdata"}, rx_rdata, x.e_rxd);
        chk({x.name, " tx_empty"}, 16'(tx_empty), 16'(x.e_txl == 4'd0));
    endtask

    task automatic step(input logic push, input logic [15:0] d, input logic rd, input logic rclr);
        @(negedge PCLK);
        tx_wr = 1'b0; tx_pop = 1'b0; sse = 1'b0; core_busy = 1'b0; ovr_clr = 1'b0;
        rx_push = push; rx_wdata = d; rx_rd = rd; rt_clr = rclr;
        @(posedge PCLK);
        #1;
        n_vec++;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " tx_level"}, 16'(tx_level), 16'h0000);
        chk({nm, " rx_level"}, 16'(rx_level), 16'h0000);
        chk({nm, " status"}, 16'(ssp_status), 16'h0003);
        chk({nm, " intr"}, 16'(intr_raw), 16'h0002);
        chk({nm, " tx_rdata"}, tx_rdata, 16'h0000);
        chk({nm, " rx_rdata"}, rx_rdata, 16'h0000);
    endtask

    initial begin
        PRESETn = 1'b0; sse = 1'b0; tx_wr = 1'b0; rx_rd = 1'b0; tx_pop = 1'b0;
        rx_push = 1'b0; core_busy = 1'b0; ovr_clr = 1'b0; rt_clr = 1'b0;
        tx_wdata = 16'h0000; rx_wdata = 16'h0000;

        // ---- table: TX fill/overflow/drain ----
        for (int i = 0; i < 8; i++) begin
            v = idle_v("tx_fill"); v.tx_wr = 1'b1; v.tx_wdata = 16'(16'h1111 * (i + 1));
            v.e_txl = 4'(i + 1); v.e_txd = 16'h1111;
            v.e_st = {3'b000, (i < 7), 1'b0}; v.e_ir = {2'b00, (i < 4), 1'b0};
            vq.push_back(v);
        end
        v = idle_v("tx_wr_full"); v.tx_wr = 1'b1; v.tx_wdata = 16'h9999;
        v.e_txl = 4'd8; v.e_txd = 16'h1111; v.e_st = 5'b00000; v.e_ir = 4'b0000;
        vq.push_back(v);
        for (int i = 0; i < 8; i++) begin
            v = idle_v("tx_drain"); v.tx_pop = 1'b1; v.e_txl = 4'(7 - i);
            v.e_txd = (i < 7) ? 16'(16'h1111 * (i + 2)) : 16'h0000;
            v.e_st = {4'b0001, (i == 7)}; v.e_ir = {2'b00, (i >= 3), 1'b0};
            vq.push_back(v);
        end
        // ---- table: pointer wrap, 5 in/out then 8 in/out ----
        for (int i = 0; i < 5; i++) begin
            v = idle_v("wrap_wr5"); v.tx_wr = 1'b1; v.tx_wdata = 16'(16'hA000 + i);
            v.e_txl = 4'(i + 1); v.e_txd = 16'hA000; v.e_st = 5'b00010;
            v.e_ir = {2'b00, (i < 4), 1'b0}; vq.push_back(v);
        end
        for (int i = 0; i < 5; i++) begin
            v = idle_v("wrap_pop5"); v.tx_pop = 1'b1; v.e_txl = 4'(4 - i);
            v.e_txd = (i < 4) ? 16'(16'hA000 + i + 1) : 16'h0000;
            v.e_st = {4'b0001, (i == 4)}; v.e_ir = 4'b0010; vq.push_back(v);
        end
        for (int i = 0; i < 8; i++) begin
            v = idle_v("wrap_wr8"); v.tx_wr = 1'b1; v.tx_wdata = 16'(16'hB000 + i);
            v.e_txl = 4'(i + 1); v.e_txd = 16'hB000; v.e_st = {3'b000, (i < 7), 1'b0};
            v.e_ir = {2'b00, (i < 4), 1'b0}; vq.push_back(v);
        end
        for (int i = 0; i < 8; i++) begin
            v = idle_v("wrap_pop8"); v.tx_pop = 1'b1; v.e_txl = 4'(7 - i);
            v.e_txd = (i < 7) ? 16'(16'hB000 + i + 1) : 16'h0000;
            v.e_st = {4'b0001, (i == 7)}; v.e_ir = {2'b00, (i >= 3), 1'b0};
            vq.push_back(v);
        end
        // ---- table: RX fill, overflow, OVR clear and set-wins ----
        for (int i = 0; i < 8; i++) begin
            v = idle_v("rx_fill"); v.rx_push = 1'b1; v.rx_wdata = 16'(16'hC000 + i);
            v.e_rxl = 4'(i + 1); v.e_rxd = 16'hC000; v.e_st = {1'b0, (i == 7), 3'b111};
            v.e_ir = {1'b0, (i >= 3), 2'b10}; vq.push_back(v);
        end
        v = idle_v("rx_ovf"); v.rx_push = 1'b1; v.rx_wdata = 16'hDEAD;
        v.e_rxl = 4'd8; v.e_rxd = 16'hC000; v.e_st = 5'b01111; v.e_ir = 4'b0111;
        vq.push_back(v);
        v = idle_v("ovr_clr"); v.ovr_clr = 1'b1;
        v.e_rxl = 4'd8; v.e_rxd = 16'hC000; v.e_st = 5'b01111; v.e_ir = 4'b0110;
        vq.push_back(v);
        v = idle_v("ovr_set_wins"); v.rx_push = 1'b1; v.rx_wdata = 16'hBEEF; v.ovr_clr = 1'b1;
        v.e_rxl = 4'd8; v.e_rxd = 16'hC000; v.e_st = 5'b01111; v.e_ir = 4'b0111;
        vq.push_back(v);
        v = idle_v("ovr_clr2"); v.ovr_clr = 1'b1;
        v.e_rxl = 4'd8; v.e_rxd = 16'hC000; v.e_st = 5'b01111; v.e_ir = 4'b0110;
        vq.push_back(v);
        v = idle_v("rx_push_rd_full"); v.rx_push = 1'b1; v.rx_wdata = 16'hE000; v.rx_rd = 1'b1;
        v.e_rxl = 4'd8; v.e_rxd = 16'hC001; v.e_st = 5'b01111; v.e_ir = 4'b0110;
        vq.push_back(v);
        for (int i = 0; i < 8; i++) begin
            v = idle_v("rx_drain"); v.rx_rd = 1'b1; v.e_rxl = 4'(7 - i);
            v.e_rxd = (i < 6) ? 16'(16'hC000 + i + 2) : ((i == 6) ? 16'hE000 : 16'h0000);
            v.e_st = {2'b00, (i < 7), 2'b11}; v.e_ir = {1'b0, (i < 4), 2'b10};
            vq.push_back(v);
        end
        v = idle_v("rx_rd_empty"); v.rx_rd = 1'b1; vq.push_back(v);
        // ---- table: simultaneous TX write/pop at empty, then BSY ----
        v = idle_v("tx_wr_pop_empty"); v.tx_wr = 1'b1; v.tx_pop = 1'b1; v.tx_wdata = 16'h1234;
        v.e_txl = 4'd1; v.e_txd = 16'h1234; v.e_st = 5'b00010; vq.push_back(v);
        v = idle_v("tx_pop_last"); v.tx_pop = 1'b1; vq.push_back(v);
        v = idle_v("tx_pop_empty"); v.tx_pop = 1'b1; vq.push_back(v);
        v = idle_v("bsy_sse0"); v.tx_wr = 1'b1; v.tx_wdata = 16'h5555;
        v.e_txl = 4'd1; v.e_txd = 16'h5555; v.e_st = 5'b00010; vq.push_back(v);
        v = idle_v("bsy_sse1"); v.sse = 1'b1;
        v.e_txl = 4'd1; v.e_txd = 16'h5555; v.e_st = 5'b10010; vq.push_back(v);
        v = idle_v("bsy_sse1_empty"); v.sse = 1'b1; v.tx_pop = 1'b1; vq.push_back(v);
        v = idle_v("bsy_core"); v.core_busy = 1'b1; v.e_st = 5'b10011; vq.push_back(v);
        v = idle_v("bsy_idle"); vq.push_back(v);

        // ---- reset ----
        repeat (2) @(posedge PCLK);
        #1;
        chk_reset("in_reset");
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        n_vec++;
        chk_reset("after_reset");

        foreach (vq[k]) apply(vq[k]);

        // ---- receive timeout fires exactly at the 64th idle cycle ----
        step(1'b1, 16'h00A5, 1'b0, 1'b0);
        chk("rt push level", 16'(rx_level), 16'h0001);
        chk("rt push rt", 16'(intr_raw[3]), 16'h0000);
        for (int n = 1; n <= 64; n++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b0);
            chk($sformatf("rt idle %0d", n), 16'(intr_raw[3]), 16'(n == 64));
        end
        repeat (3) step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("rt held", 16'(intr_raw[3]), 16'h0001);
        chk("rt rdata", rx_rdata, 16'h00A5);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("rt rd rt", 16'(intr_raw[3]), 16'h0000);
        chk("rt rd rne", 16'(ssp_status[2]), 16'h0000);
        chk("rt rd rdata", rx_rdata, 16'h0000);

        // ---- rt_clr, clear-wins and fresh window ----
        step(1'b1, 16'h0011, 1'b0, 1'b0);
        repeat (64) step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("rt2 fired", 16'(intr_raw[3]), 16'h0001);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("rt2 clr", 16'(intr_raw[3]), 16'h0000);
        repeat (10) step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("rt2 no refire", 16'(intr_raw[3]), 16'h0000);
        step(1'b1, 16'h0022, 1'b0, 1'b0);
        repeat (63) step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("rt3 idle63", 16'(intr_raw[3]), 16'h0000);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("rt3 clr wins", 16'(intr_raw[3]), 16'h0000);
        repeat (5) step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("rt3 stays", 16'(intr_raw[3]), 16'h0000);
        chk("rt3 head", rx_rdata, 16'h0011);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("rt4 level", 16'(rx_level), 16'h0001);
        chk("rt4 head", rx_rdata, 16'h0022);
        repeat (63) step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("rt4 idle63", 16'(intr_raw[3]), 16'h0000);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("rt4 idle64", 16'(intr_raw[3]), 16'h0001);

        // ---- asynchronous reset mid-operation ----
        @(negedge PCLK);
        rx_rd = 1'b0; tx_wr = 1'b1; tx_wdata = 16'h7777;
        @(posedge PCLK);
        #1;
        tx_wr = 1'b0;
        chk("pre_rst tx_level", 16'(tx_level), 16'h0001);
        #2;
        PRESETn = 1'b0;
        #1;
        chk_reset("mid_reset");
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        n_vec++;
        chk_reset("post_mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
